// File: rtl/tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter_pkg
// Brief    : Shared types and constants for the UART transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tx_arbiter_pkg;

    // One UART frame on the wire: START + 8 data bits + STOP
    localparam int FRAME_CYCLES = 10;
    localparam int BYTE_WIDTH   = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arbState_t;

    // Requester index reached by stepping 'offset' places past 'ptr'
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned offset,
                                            input int unsigned n);
        return (ptr + offset) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter_if
// Brief    : Requester-side and transmitter-side signals of the arbiter.
//            master = arbiter view, slave = surrounding system view.
// Revision : 1.0 - initial release
// ============================================================================
interface tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import tx_arbiter_pkg::*;

    localparam int c_ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            reqValid;
    logic [NUM_REQ*BYTE_WIDTH-1:0] reqByte;
    logic [NUM_REQ-1:0]            reqReady;
    logic                          txSend;
    logic [BYTE_WIDTH-1:0]         txByte;
    logic                          txDone;
    logic                          busy;
    logic [c_ID_W-1:0]             activeId;
    logic                          timeoutErr;

    modport master (
        input  reqValid, reqByte, txDone,
        output reqReady, txSend, txByte, busy, activeId, timeoutErr
    );

    modport slave (
        output reqValid, reqByte, txDone,
        input  reqReady, txSend, txByte, busy, activeId, timeoutErr
    );

endinterface
`default_nettype wire

// File: rtl/tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Search begins one place past
//            i_rrPtr and wraps; the first valid requester wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  wire logic [NUM_REQ-1:0]         i_reqValid,
    input  wire logic [$clog2(NUM_REQ)-1:0] i_rrPtr,
    output logic      [NUM_REQ-1:0]         o_grant,
    output logic      [$clog2(NUM_REQ)-1:0] o_grantIdx,
    output logic                            o_anyValid
);

    localparam int c_ID_W = $clog2(NUM_REQ);

    logic              w_found;
    logic [c_ID_W-1:0] w_cand;

    assign o_anyValid = |i_reqValid;

    // Walk the requesters in rotation order, offset 1 .. NUM_REQ from the pointer
    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = c_ID_W'(rr_next(32'(i_rrPtr), k, NUM_REQ));
            if (!w_found && i_reqValid[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_grantIdx      = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Brief    : Round-robin scheduler sharing one UART transmitter among
//            NUM_REQ byte producers. Holds the accepted byte for the whole
//            frame and chains frames back-to-back using the transmitter's
//            STOP-cycle done strobe. Watchdog aborts a frame that never ends.
// Revision : 1.0 - initial release
// ============================================================================
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  wire logic     clk,
    input  wire logic     rst,      // asynchronous, active-low
    tx_arbiter_if.master  bus
);

    localparam int                c_ID_W   = $clog2(NUM_REQ);
    localparam int                c_WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CYCLES - 1);

    arbState_t               r_state;
    arbState_t               w_nextState;
    logic [c_ID_W-1:0]       r_rrPtr;
    logic [c_ID_W-1:0]       r_activeId;
    logic [BYTE_WIDTH-1:0]   r_txByte;
    logic [c_WD_W-1:0]       r_wdCnt;

    logic [NUM_REQ-1:0]      w_grant;
    logic [c_ID_W-1:0]       w_grantIdx;
    logic                    w_anyValid;
    logic                    w_acceptWin;
    logic                    w_accept;
    logic                    w_wdExpire;
    logic [BYTE_WIDTH-1:0]   w_lane [NUM_REQ];

    logic [NUM_REQ-1:0]      w_reqReady;
    logic                    w_txSend;
    logic                    w_busy;
    logic                    w_timeoutErr;

    // Split the flat byte bus into one lane per requester
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign w_lane[gi] = bus.reqByte[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_arbiter (
        .i_reqValid (bus.reqValid),
        .i_rrPtr    (r_rrPtr),
        .o_grant    (w_grant),
        .o_grantIdx (w_grantIdx),
        .o_anyValid (w_anyValid)
    );

    // A byte can be taken while idle, or in the STOP cycle of the running
    // frame so the next START follows with no idle bit. Held off in reset
    // so reqReady is quiet while rst is low.
    assign w_acceptWin = rst & ((r_state == ARB_IDLE) ||
                                ((r_state == ARB_WAIT) && bus.txDone));
    assign w_accept    = w_acceptWin & w_anyValid;
    assign w_wdExpire  = (r_state == ARB_WAIT) && !bus.txDone && (r_wdCnt == c_WD_MAX);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_accept) begin
                    w_nextState = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                w_nextState = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (bus.txDone) begin
                    // Chained accept stays in WAIT; otherwise the line goes quiet
                    if (!w_anyValid) begin
                        w_nextState = ARB_IDLE;
                    end
                end else if (w_wdExpire) begin
                    w_nextState = ARB_IDLE;
                end
            end
            default: begin
                w_nextState = ARB_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and handshake inputs
    always_comb begin
        w_reqReady   = w_acceptWin ? w_grant : '0;
        w_txSend     = (r_state == ARB_ISSUE) || ((r_state == ARB_WAIT) && w_accept);
        w_busy       = (r_state == ARB_ISSUE) || (r_state == ARB_WAIT);
        w_timeoutErr = w_wdExpire;
    end

    // Winner bookkeeping and the held byte; only an accept changes them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rrPtr    <= c_ID_W'(NUM_REQ - 1);
            r_activeId <= '0;
            r_txByte   <= '0;
        end else if (w_accept) begin
            r_rrPtr    <= w_grantIdx;
            r_activeId <= w_grantIdx;
            r_txByte   <= w_lane[w_grantIdx];
        end
    end

    // Watchdog: counts WAIT cycles since the last frame was issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdCnt <= '0;
        end else if ((r_state == ARB_WAIT) && !bus.txDone && !w_wdExpire) begin
            r_wdCnt <= r_wdCnt + 1'b1;
        end else begin
            r_wdCnt <= '0;
        end
    end

    assign bus.reqReady   = w_reqReady;
    assign bus.txSend     = w_txSend;
    assign bus.txByte     = r_txByte;
    assign bus.busy       = w_busy;
    assign bus.activeId   = r_activeId;
    assign bus.timeoutErr = w_timeoutErr;

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_arbiter
// Brief    : Self-checking bench for tx_arbiter with a behavioural UART
//            transmitter and a byte scoreboard on the serial side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_arbiter;
    import tx_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural transmitter ----------------
    localparam logic [1:0] M_IDLE = 2'd0, M_START = 2'd1, M_DATA = 2'd2, M_STOP = 2'd3;
    logic [1:0] m_state;
    logic [2:0] m_bit;
    logic [7:0] m_shift;
    logic       tx_mute = 1'b0;
    logic       serial;
    logic       rx_valid;

    // Data bits are read from txByte live each cycle, so a byte that moves
    // mid-frame shows up as a corrupted received value.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= M_IDLE;
            m_bit   <= 3'd0;
            m_shift <= 8'h00;
        end else begin
            case (m_state)
                M_IDLE:  if (bus.txSend && !tx_mute) m_state <= M_START;
                M_START: begin m_state <= M_DATA; m_bit <= 3'd0; end
                M_DATA: begin
                    m_shift[m_bit] <= bus.txByte[m_bit];
                    if (m_bit == 3'd7) m_state <= M_STOP;
                    else               m_bit   <= m_bit + 3'd1;
                end
                default: m_state <= bus.txSend ? M_START : M_IDLE;
            endcase
        end
    end

    assign bus.txDone = (m_state == M_STOP);
    assign rx_valid   = (m_state == M_STOP);
    assign serial     = (m_state == M_START) ? 1'b0 :
                        (m_state == M_DATA)  ? bus.txByte[m_bit] : 1'b1;

    // ---------------- checking infrastructure ----------------
    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    logic [7:0] expq[$];
    int         starts[$];
    int         grants[$];

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] bytes;
        logic [3:0]  expReady;
        logic [1:0]  expId;
        logic [7:0]  expByte;
    } vec_t;
    vec_t vec[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        if (m_state == M_START) starts.push_back(cyc);
        if (rx_valid) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected: got frame %0h expected none", m_shift);
            end else begin
                e = expq.pop_front();
                chk("sb_byte", {24'h0, m_shift}, {24'h0, e});
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.reqValid = '0;
        step();
        step();
        rst = 1'b1;
        starts.delete();
        grants.delete();
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (!bus.busy && m_state == M_IDLE) done = 1'b1;
            else step();
        end
        if (!done && !(!bus.busy && m_state == M_IDLE)) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_idle: got busy=%0b expected idle within %0d cycles", bus.busy, budget);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Run until n grants have been observed; optionally drop each winner after its grant
    task automatic collect_grants(input int n, input bit drop_winner, input bit fair_mode);
        int g;
        int ng;
        ng = 0;
        for (int i = 0; i < 120 && ng < n; i++) begin
            #1;
            g = -1;
            if (|(bus.reqValid & bus.reqReady)) begin
                g = oh2idx(bus.reqValid & bus.reqReady);
                grants.push_back(g);
                if (ng > 0) chk("grant_on_done", {31'h0, bus.txDone}, 32'd1);
                ng++;
            end
            step();
            if (g >= 0 && drop_winner) bus.reqValid[g] = 1'b0;
            if (g >= 0 && fair_mode && ng == 1) begin
                bus.reqByte[8*1 +: 8] = 8'h11;
                bus.reqByte[8*3 +: 8] = 8'h33;
                bus.reqValid = 4'b1010;
                expq.push_back(8'h33);
                expq.push_back(8'h11);
            end
        end
        if (ng < n) begin
            n_checks++;
            n_err++;
            $display("FAIL grant_count: got %0d expected %0d", ng, n);
        end
    endtask

    initial begin
        logic [9:0] ser;
        logic [9:0] ser_exp;
        int         bad;
        int         tpulse;
        int         tcount;
        int         scount;
        int         exp_order[5];

        vec[0] = '{4'b0001, 32'h44332211, 4'b0001, 2'd0, 8'h11};
        vec[1] = '{4'b0010, 32'h44332211, 4'b0010, 2'd1, 8'h22};
        vec[2] = '{4'b0100, 32'h44332211, 4'b0100, 2'd2, 8'h33};
        vec[3] = '{4'b1000, 32'h44332211, 4'b1000, 2'd3, 8'h44};
        vec[4] = '{4'b1100, 32'hD4C3B2A1, 4'b0100, 2'd2, 8'hC3};
        vec[5] = '{4'b1111, 32'hD4C3B2A1, 4'b0001, 2'd0, 8'hA1};
        vec[6] = '{4'b1010, 32'h0F1E2D3C, 4'b0010, 2'd1, 8'h2D};
        vec[7] = '{4'b0000, 32'hFFFFFFFF, 4'b0000, 2'd0, 8'h00};

        bus.reqValid = '0;
        bus.reqByte  = '0;

        // ---- reset values ----
        #1;
        chk("rst_reqReady",   {28'h0, bus.reqReady}, 32'h0);
        chk("rst_txSend",     {31'h0, bus.txSend},   32'h0);
        chk("rst_busy",       {31'h0, bus.busy},     32'h0);
        chk("rst_timeoutErr", {31'h0, bus.timeoutErr}, 32'h0);
        chk("rst_txByte",     {24'h0, bus.txByte},   32'h0);
        chk("rst_activeId",   {30'h0, bus.activeId}, 32'h0);

        // ---- table: first grant after reset (pointer at NUM_REQ-1) ----
        for (int v = 0; v < 8; v++) begin
            do_reset();
            bus.reqByte  = vec[v].bytes;
            bus.reqValid = vec[v].valid;
            if (vec[v].valid != 4'b0000) expq.push_back(vec[v].expByte);
            #1;
            chk("tbl_reqReady", {28'h0, bus.reqReady}, {28'h0, vec[v].expReady});
            step();
            if (vec[v].valid != 4'b0000) begin
                chk("tbl_activeId", {30'h0, bus.activeId}, {30'h0, vec[v].expId});
                chk("tbl_txByte",   {24'h0, bus.txByte},   {24'h0, vec[v].expByte});
                chk("tbl_txSend",   {31'h0, bus.txSend},   32'd1);
                chk("tbl_issue_ready", {28'h0, bus.reqReady}, 32'h0);
                bus.reqValid = '0;
                wait_idle(30);
            end else begin
                chk("tbl_idle_busy",   {31'h0, bus.busy},   32'h0);
                chk("tbl_idle_txSend", {31'h0, bus.txSend}, 32'h0);
            end
        end

        // ---- single byte A5: timing and serial line ----
        do_reset();
        bus.reqByte[7:0] = 8'hA5;
        bus.reqValid     = 4'b0001;
        expq.push_back(8'hA5);
        #1;
        chk("single_ready_T",  {28'h0, bus.reqReady}, 32'h1);
        chk("single_send_T",   {31'h0, bus.txSend},   32'h0);
        step();
        chk("single_send_T1",  {31'h0, bus.txSend},   32'h1);
        bus.reqValid = '0;
        ser_exp = 10'b11_0100_1010; // index 0 = START, then A5 LSB first, then STOP
        ser = '0;
        scount = 0;
        for (int i = 2; i <= 12; i++) begin
            step();
            if (i <= 11) ser[i-2] = serial;
            if (bus.txSend) scount++;
            if (i == 10) chk("single_done_T10", {31'h0, bus.txDone}, 32'h0);
            if (i == 11) begin
                chk("single_done_T11", {31'h0, bus.txDone}, 32'h1);
                chk("single_busy_T11", {31'h0, bus.busy},   32'h1);
            end
            if (i == 12) chk("single_busy_T12", {31'h0, bus.busy}, 32'h0);
        end
        chk("single_serial", {22'h0, ser}, {22'h0, ser_exp});
        chk("single_send_once", scount, 0);

        // ---- contention: all four valid ----
        do_reset();
        bus.reqByte  = 32'h13121110;
        bus.reqValid = 4'b1111;
        expq.push_back(8'h10); expq.push_back(8'h11); expq.push_back(8'h12);
        expq.push_back(8'h13); expq.push_back(8'h10);
        collect_grants(5, 1'b0, 1'b0);
        bus.reqValid = '0;
        wait_idle(30);
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < grants.size()) chk("cont_order", grants[i], exp_order[i]);
        end
        chk("cont_starts", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++) chk("cont_spacing", starts[i] - starts[i-1], FRAME_CYCLES);

        // ---- fairness: req2 just served, then req1 and req3 ----
        do_reset();
        bus.reqByte[8*2 +: 8] = 8'h22;
        bus.reqValid = 4'b0100;
        expq.push_back(8'h22);
        collect_grants(3, 1'b1, 1'b1);
        wait_idle(30);
        if (grants.size() == 3) begin
            chk("fair_first",  grants[0], 2);
            chk("fair_second", grants[1], 3);
            chk("fair_third",  grants[2], 1);
        end else begin
            chk("fair_count", grants.size(), 3);
        end

        // ---- stability: requester byte changes every cycle after accept ----
        do_reset();
        bus.reqByte[7:0] = 8'h5C;
        bus.reqValid     = 4'b0001;
        expq.push_back(8'h5C);
        #1;
        chk("stab_ready", {28'h0, bus.reqReady}, 32'h1);
        step();
        bus.reqValid = '0;
        bad = 0;
        for (int i = 0; i < 11; i++) begin
            bus.reqByte[7:0] = 8'($urandom);
            step();
            if (bus.txByte !== 8'h5C) bad++;
        end
        chk("stab_txByte_held", bad, 0);
        wait_idle(30);

        // ---- watchdog: transmitter never reports done ----
        do_reset();
        tx_mute = 1'b1;
        bus.reqByte[7:0] = 8'h3C;
        bus.reqValid     = 4'b0001;
        step();
        bus.reqValid = '0;
        tpulse = -1;
        tcount = 0;
        scount = 0;
        for (int i = 2; i <= 18; i++) begin
            step();
            if (bus.timeoutErr) begin tcount++; tpulse = i; end
            if (bus.txSend) scount++;
            if (i == 17) chk("wd_busy_after", {31'h0, bus.busy}, 32'h0);
        end
        chk("wd_pulse_count", tcount, 1);
        chk("wd_pulse_cycle", tpulse, 16);
        chk("wd_no_send", scount, 0);
        tx_mute = 1'b0;

        // ---- reset during data bits ----
        do_reset();
        bus.reqByte[8*2 +: 8] = 8'h77;
        bus.reqValid = 4'b0100;
        step();
        bus.reqValid = '0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_activeId_pre", {30'h0, bus.activeId}, 32'd2);
        #2;
        rst = 1'b0;
        bus.reqByte  = 32'h0000B1A0;
        bus.reqValid = 4'b0011;
        #1;
        chk("mid_rst_txByte",   {24'h0, bus.txByte},   32'h0);
        chk("mid_rst_activeId", {30'h0, bus.activeId}, 32'h0);
        chk("mid_rst_busy",     {31'h0, bus.busy},     32'h0);
        chk("mid_rst_txSend",   {31'h0, bus.txSend},   32'h0);
        chk("mid_rst_reqReady", {28'h0, bus.reqReady}, 32'h0);
        step();
        rst = 1'b1;
        expq.push_back(8'hA0);
        #1;
        chk("post_rst_grant0", {28'h0, bus.reqReady}, 32'h1);
        step();
        bus.reqValid = '0;
        wait_idle(30);
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.reqValid = 4'b0010;
        expq.push_back(8'hB1);
        #1;
        chk("post_rst_grant1", {28'h0, bus.reqReady}, 32'h2);
        step();
        bus.reqValid = '0;
        wait_idle(30);

        chk("sb_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish by 400000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
- Accepts one byte at a time from the requesters, holds it stable for the whole frame, and drives the transmitter's send/byteToLoad.
- Uses the transmitter's done (high during its STOP cycle) to issue frames back-to-back.
- Sits between the per-source TX buffers and the transmitter, on the same (baud) clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 15, maximum cycles in ARB_WAIT without txDone before abort (must be > FRAME_CYCLES).

Ports:
- clk  input  1  transmitter/baud clock
- rst  input  1  asynchronous, active-low reset
- reqValid  input  NUM_REQ  per-requester byte available
- reqByte  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
- reqReady  output  NUM_REQ  one-hot accept strobe; byte i consumed when reqValid[i]&reqReady[i]
- txSend  output  1  to transmitter send
- txByte  output  8  to transmitter byteToLoad; held-byte register
- txDone  input  1  from transmitter done
- busy  output  1  high in ARB_ISSUE/ARB_WAIT
- activeId  output  clog2(NUM_REQ)  index of the requester owning the current frame
- timeoutErr  output  1  single-cycle pulse on watchdog abort

Behaviour:
- Reset (rst low, async):
  - state=ARB_IDLE; txByte=8'h00; activeId=0; rrPtr=NUM_REQ-1; wdCnt=0.
  - reqReady=0, txSend=0, busy=0, timeoutErr=0.
- Arbitration:
  - Round-robin: search starts at rrPtr+1 (mod NUM_REQ); first valid requester wins.
  - On accept: rrPtr<=winner, activeId<=winner, txByte<=reqByte[winner].
  - reqReady is combinational and one-hot. It is asserted only in an accept window: (state==ARB_IDLE) or (state==ARB_WAIT && txDone).
- States:
  - ARB_IDLE: if any reqValid, accept winner -> ARB_ISSUE; else stay.
  - ARB_ISSUE: txSend=1 for exactly this cycle (transmitter is in IDLE) -> ARB_WAIT; wdCnt<=0.
  - ARB_WAIT: wdCnt increments each cycle.
    - If txDone and any reqValid: accept winner same cycle, txSend=1 combinationally (transmitter goes STOP->START); stay in ARB_WAIT; wdCnt<=0.
    - If txDone and no reqValid: -> ARB_IDLE.
    - If wdCnt==TIMEOUT_CYCLES-1 without txDone: pulse timeoutErr, -> ARB_IDLE. The byte is dropped, not retried.
- txSend = (state==ARB_ISSUE) | (state==ARB_WAIT & txDone & |reqValid). txSend is never asserted in ARB_IDLE.
- Latency:
  - Accept at cycle T; txSend at T+1; transmitter START at T+2; STOP/txDone at T+11.
  - Back-to-back: next START at T+12, so there is no idle bit between frames.
- txByte changes only on an accept. It is stable from the accept until the next accept, covering all 8 data cycles.
- Simultaneous requests: exactly one grant per accept window; the others wait. No requester is starved: worst-case wait is NUM_REQ-1 frames.
- reqValid dropped by a requester before its grant: no effect, nothing latched.
- txDone outside ARB_WAIT: ignored.
- Mid-frame reset: the controller returns to ARB_IDLE immediately. The transmitter must be reset from the same source (inverted, synchronised) at integration.

Decomposition:
- Add to uartUtil package:
  - arbState_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}
  - constant FRAME_CYCLES=10 (START+8 data+STOP)
  - constant BYTE_WIDTH=8
- One sub-module, rr_arbiter:
  - combinational round-robin picker over reqValid with rrPtr input
  - returns a one-hot grant and a binary index
  - parameterised by NUM_REQ

Test Plan:
- Single byte: req0 sends 8'hA5 from idle -> reqReady[0] at T; txSend at T+1 only. Transmitter serial line: 0,1,0,1,0,0,1,0,1 (LSB first), then 1. busy falls at T+12.
- Contention: all 4 valid continuously, bytes 8'h10..8'h13 -> grant order 0,1,2,3,0. Each subsequent grant coincides with txDone, and consecutive START bits are exactly 10 cycles apart.
- Round-robin fairness: req2 just served, req1 and req3 both valid -> req3 granted first, then req1.
- Stability: change reqByte[0] every cycle after its accept -> txByte holds the accepted value until the next accept; the transmitted data bits match the accepted value.
- Watchdog: tie txDone=0 after an accept -> timeoutErr pulses 1 cycle at wdCnt==14, state returns to ARB_IDLE, txSend remains 0.
- Reset: assert rst low during the data bits of a frame -> all outputs reach their reset values asynchronously. After release with req1 valid, the first grant goes to req0 if valid, otherwise req1 (rrPtr=3).
